oddr_pattern_gen: RTL and testbench
===================================

// Module: oddr_pattern_gen
// PURPOSE
//  Pattern source directly upstream of the ODDR test wrapper. Produces per-lane
//  rising/falling data pairs (d1/d2) for LANES ODDR primitives on clk_100m.
//  Runs bursts or continuous streams of selectable patterns under enable/start
//  control. Reports busy/done and a word count to the VIO for lab bring-up.
// PARAMETERS
//  LANES    8   number of ODDR lanes; width of d1/d2
//  BURST_W  16  width of burst_len and word_cnt
// PORTS
//  clk        in   1        system clock (clk_100m from clk_wiz_0)
//  rst_n      in   1        synchronous, active-low reset
//  enable     in   1        global enable; low forces IDLE
//  start      in   1        level; sampled only in IDLE
//  mode       in   3        pattern select (patgen_mode_e), latched at start
//  burst_len  in   BURST_W  words per burst, latched at start; 0 = continuous
//  d1         out  LANES    rising-edge data to ODDR D1
//  d2         out  LANES    falling-edge data to ODDR D2
//  oe         out  1        high exactly while d1/d2 carry pattern words
//  busy       out  1        high in ARM and RUN
//  done       out  1        one-cycle pulse after a finite burst completes
//  word_cnt   out  BURST_W  words issued in current/last burst; wraps at 2^BURST_W
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=IDLE; d1=d2=0; oe=busy=done=0;
//   word_cnt=0; LFSR=7'h7F.
//  All outputs are registered.
//  FSM IDLE->ARM->RUN->DONE->IDLE:
//   IDLE: if enable&&start -> ARM; latch mode and burst_len; clear word_cnt.
//   ARM: seed generator (LFSR=7'h7F, walk=1, count=0) -> RUN.
//    At this edge d1/d2 load word 0 and oe=1.
//   RUN: each edge loads the next word and increments word_cnt.
//    With burst_len=N>0: when word_cnt==N-1 at an edge -> DONE.
//    oe therefore stays high exactly N cycles.
//   DONE: d1=d2=0, oe=0, done=1 for one cycle -> IDLE.
//   If start is still high in DONE, IDLE re-arms on the following edge.
//  burst_len=0: RUN continues until enable falls; word_cnt wraps; no done.
//  enable low in any state: -> IDLE next edge; d1=d2=0, oe=busy=0, no done.
//   word_cnt holds its value.
//  Word k by mode:
//   0 ZERO: d1=d2=0
//   1 CLKFWD: d1=all 1s, d2=0 (forwarded clock)
//   2 TOGGLE: d1=0x55.., d2=0xAA.. (per-lane alternation)
//   3 COUNT: d1=k[LANES-1:0], d2=~d1
//   4 WALK1: d1=1<<(k%LANES), d2=1<<((k+1)%LANES)
//   5 PRBS7: x^7+x^6+1, stepped 2*LANES bits per cycle; d1=bits[LANES-1:0]
//    (first generated), d2=next LANES bits; sequence continues across words.
//   6,7: reserved, behave as ZERO (oe still asserted).
//  Changes to mode/burst_len mid-burst are ignored.
//  rst_n low mid-burst -> reset values on that edge.
// CONFIGURATION
//  `ODDR_PATGEN_ERR_INJ_EN defined:
//   - adds input err_inj (1 bit) and output err_cnt (8 bits, saturating, reset 0).
//   - err_inj high at an edge in RUN inverts d1[0] of the word loaded at the
//     next edge and increments err_cnt.
//   - Injection does not perturb the LFSR/counter sequence.
//  Not defined: ports absent; behaviour as above.
// STRUCTURE
//  oddr_test_pkg holds:
//   - patgen_mode_e (3-bit enum)
//   - patgen_state_e (IDLE/ARM/RUN/DONE)
//   - PRBS7_SEED=7'h7F and PRBS7 tap constants
//  Sub-module oddr_prbs7_gen: LFSR register plus unrolled 2*LANES-step next-state
//   function; inputs seed_load, advance; output 2*LANES bits.
// TESTING
//  1 Reset: rst_n low 3 cycles -> all outputs 0, state IDLE, no done.
//  2 COUNT, burst_len=4, start 1 cycle:
//     -> oe high 4 cycles, d1=0,1,2,3, d2=FF,FE,FD,FC;
//     -> done one cycle after last word; word_cnt=4.
//  3 CLKFWD, burst_len=0:
//     -> d1=FF, d2=00 continuously;
//     -> enable dropped -> next edge oe=0, d1=d2=0, no done.
//  4 WALK1, LANES=8, burst_len=10 -> d1 =01,02,..,80,01,02.
//  5 PRBS7, burst_len=127:
//     -> d1/d2 match golden LFSR model from seed 7'h7F;
//     -> rst_n low at word 50 -> outputs 0 next edge.
//  6 ERR_INJ_EN build, PRBS7 run:
//     -> err_inj pulse at word 10 -> word 11 d1[0] flipped vs model;
//     -> word 12 matches model; err_cnt=1.

Source files
------------

// File: rtl/oddr_test_pkg.sv
// Shared types and PRBS7 constants for the ODDR test pattern source.
package oddr_test_pkg;

  typedef enum logic [2:0] {
    MODE_ZERO   = 3'd0,
    MODE_CLKFWD = 3'd1,
    MODE_TOGGLE = 3'd2,
    MODE_COUNT  = 3'd3,
    MODE_WALK1  = 3'd4,
    MODE_PRBS7  = 3'd5,
    MODE_RSVD6  = 3'd6,
    MODE_RSVD7  = 3'd7
  } patgen_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } patgen_state_e;

  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  // One step of x^7+x^6+1; the new bit enters at bit 0.
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
  endfunction

endpackage

// File: rtl/oddr_prbs7_gen.sv
// PRBS7 LFSR advanced STEPS bits per cycle.
// bits[0] is the first bit generated from the current state.
module oddr_prbs7_gen
  import oddr_test_pkg::*;
#(
  parameter int STEPS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic             advance,
  output logic [STEPS-1:0] bits
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_n;

  always_comb begin
    lfsr_n = lfsr_q;
    bits   = '0;
    for (int i = 0; i < STEPS; i++) begin
      lfsr_n  = prbs7_step(lfsr_n);
      bits[i] = lfsr_n[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      lfsr_q <= PRBS7_SEED;
    else if (seed_load)
      lfsr_q <= PRBS7_SEED;
    else if (advance)
      lfsr_q <= lfsr_n;
  end

endmodule

// File: rtl/oddr_pattern_gen.sv
// Burst/continuous pattern source feeding LANES ODDR primitives.
// Optional error injection: define ODDR_PATGEN_ERR_INJ_EN.
module oddr_pattern_gen
  import oddr_test_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
`ifdef ODDR_PATGEN_ERR_INJ_EN
  input  logic               err_inj,
  output logic [7:0]         err_cnt,
`endif
  output logic [LANES-1:0]   d1,
  output logic [LANES-1:0]   d2,
  output logic               oe,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] word_cnt
);

  patgen_state_e      state_q, state_d;
  patgen_mode_e       mode_q, mode_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] cnt_d;
  logic [LANES-1:0]   k_q, k_d;
  logic [LANES-1:0]   walk_q, walk_d;
  logic [LANES-1:0]   d1_d, d2_d, tog;
  logic               busy_d, done_d;
  logic               load_word, seed_load;
  logic [2*LANES-1:0] prbs_bits;

  oddr_prbs7_gen #(
    .STEPS(2*LANES)
  ) u_prbs (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed_load(seed_load),
    .advance  (load_word),
    .bits     (prbs_bits)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    cnt_d     = word_cnt;
    k_d       = k_q;
    walk_d    = walk_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    load_word = 1'b0;
    seed_load = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          state_d   = ST_ARM;
          mode_d    = patgen_mode_e'(mode);
          len_d     = burst_len;
          cnt_d     = '0;
          k_d       = '0;
          walk_d    = LANES'(1);
          seed_load = 1'b1;
          busy_d    = 1'b1;
        end
        ST_ARM: begin
          state_d   = ST_RUN;
          load_word = 1'b1;
        end
        // word_cnt already counts the words shown, so N means finished
        ST_RUN: if (len_q != '0 && word_cnt == len_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          load_word = 1'b1;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    if (load_word) begin
      busy_d = 1'b1;
      cnt_d  = word_cnt + BURST_W'(1);
      k_d    = k_q + LANES'(1);
      walk_d = (walk_q << 1) | (walk_q >> (LANES-1));
    end
  end

  always_comb begin
    tog  = '0;
    d1_d = '0;
    d2_d = '0;
    for (int i = 0; i < LANES; i++)
      tog[i] = (i % 2) == 0;
    if (load_word) begin
      case (mode_q)
        MODE_CLKFWD: d1_d = '1;
        MODE_TOGGLE: begin
          d1_d = tog;
          d2_d = ~tog;
        end
        MODE_COUNT: begin
          d1_d = k_q;
          d2_d = ~k_q;
        end
        MODE_WALK1: begin
          d1_d = walk_q;
          d2_d = (walk_q << 1) | (walk_q >> (LANES-1));
        end
        MODE_PRBS7: begin
          d1_d = prbs_bits[LANES-1:0];
          d2_d = prbs_bits[2*LANES-1:LANES];
        end
        default: ;
      endcase
`ifdef ODDR_PATGEN_ERR_INJ_EN
      if (err_inj && state_q == ST_RUN)
        d1_d[0] = ~d1_d[0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_ZERO;
      len_q    <= '0;
      k_q      <= '0;
      walk_q   <= LANES'(1);
      word_cnt <= '0;
      d1       <= '0;
      d2       <= '0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      k_q      <= k_d;
      walk_q   <= walk_d;
      word_cnt <= cnt_d;
      d1       <= d1_d;
      d2       <= d2_d;
      oe       <= load_word;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

`ifdef ODDR_PATGEN_ERR_INJ_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (load_word && err_inj && state_q == ST_RUN && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_oddr_pattern_gen.sv
// Self-checking bench for oddr_pattern_gen with a sequence-level model.
module tb_oddr_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n, enable, start;
  logic [2:0]  mode;
  logic [15:0] burst_len;
  logic [7:0]  d1, d2;
  logic        oe, busy, done;
  logic [15:0] word_cnt;
`ifdef ODDR_PATGEN_ERR_INJ_EN
  logic        err_inj;
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  bit prbs_e[0:133];

  oddr_pattern_gen #(.LANES(8), .BURST_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .mode(mode), .burst_len(burst_len),
`ifdef ODDR_PATGEN_ERR_INJ_EN
    .err_inj(err_inj), .err_cnt(err_cnt),
`endif
    .d1(d1), .d2(d2), .oe(oe), .busy(busy), .done(done),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // m-sequence of x^7+x^6+1 starting from seven ones
  task automatic build_prbs;
    for (int n = 0; n < 7; n++) prbs_e[n] = 1'b1;
    for (int n = 7; n < 134; n++) prbs_e[n] = prbs_e[n-7] ^ prbs_e[n-6];
  endtask

  function automatic bit prbs_bit(int n);
    return prbs_e[7 + (n % 127)];
  endfunction

  // returns {d1,d2} for word k of mode m
  function automatic logic [15:0] model(int m, int k);
    logic [7:0] a, b;
    a = '0;
    b = '0;
    case (m)
      1: a = 8'hFF;
      2: begin a = 8'h55; b = 8'hAA; end
      3: begin a = k[7:0]; b = ~a; end
      4: begin a = 8'd1 << (k % 8); b = 8'd1 << ((k + 1) % 8); end
      5: for (int i = 0; i < 8; i++) begin
        a[i] = prbs_bit(16*k + i);
        b[i] = prbs_bit(16*k + 8 + i);
      end
      default: ;
    endcase
    return {a, b};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'($urandom);
    start = 1'b1;
    mode = 3'($urandom);
    burst_len = 16'($urandom);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({d1, d2, oe, busy, done, word_cnt} !== '0) begin
        fails++;
        $display("FAIL reset cyc%0d: got d1=%h d2=%h oe=%b busy=%b done=%b cnt=%0d want all 0",
                 c, d1, d2, oe, busy, done, word_cnt);
      end
    end
    rst_n = 1'b1;
    start = 1'b0;
    enable = 1'b1;
    tick();
    checks++;
    if ({oe, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: got oe/busy/done=%b%b%b want 000", oe, busy, done);
    end
  endtask

  task automatic test_count;
    mode = 3'd3;
    burst_len = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, oe} !== 2'b10) begin
      fails++;
      $display("FAIL count_arm: got busy=%b oe=%b want busy=1 oe=0", busy, oe);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({oe, d1, d2, word_cnt} !== {1'b1, model(3, k), 16'(k + 1)}) begin
        fails++;
        $display("FAIL count_w%0d: got oe=%b d1=%h d2=%h cnt=%0d want oe=1 %h cnt=%0d",
                 k, oe, d1, d2, word_cnt, model(3, k), k + 1);
      end
      mode = 3'($urandom);
      burst_len = 16'($urandom);
      tick();
    end
    checks++;
    if ({done, oe, busy, d1, d2, word_cnt} !== {3'b100, 16'h0, 16'd4}) begin
      fails++;
      $display("FAIL count_done: got done=%b oe=%b busy=%b d1=%h d2=%h cnt=%0d want done=1 cnt=4",
               done, oe, busy, d1, d2, word_cnt);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      fails++;
      $display("FAIL count_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_walk1;
    mode = 3'd4;
    burst_len = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({oe, d1, d2} !== {1'b1, model(4, k)}) begin
        fails++;
        $display("FAIL walk1_w%0d: got oe=%b d1=%h d2=%h want %h",
                 k, oe, d1, d2, model(4, k));
      end
      tick();
    end
    checks++;
    if ({done, oe} !== 2'b10) begin
      fails++;
      $display("FAIL walk1_done: got done=%b oe=%b want 1 0", done, oe);
    end
    tick();
  endtask

  task automatic test_random_bursts;
    for (int b = 0; b < 10; b++) begin
      int m, len;
      m = $urandom_range(0, 7);
      len = $urandom_range(1, 24);
      mode = 3'(m);
      burst_len = 16'(len);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < len; k++) begin
        checks++;
        if ({oe, busy, done, d1, d2} !== {3'b110, model(m, k)}) begin
          fails++;
          $display("FAIL rnd_b%0d_m%0d_w%0d: got oe=%b busy=%b done=%b d1=%h d2=%h want %h",
                   b, m, k, oe, busy, done, d1, d2, model(m, k));
        end
        mode = 3'($urandom);
        burst_len = 16'($urandom);
        tick();
      end
      checks++;
      if ({done, oe, word_cnt} !== {2'b10, 16'(len)}) begin
        fails++;
        $display("FAIL rnd_b%0d_done: got done=%b oe=%b cnt=%0d want done=1 oe=0 cnt=%0d",
                 b, done, oe, word_cnt, len);
      end
      tick();
    end
  endtask

  task automatic test_continuous;
    int n;
    n = $urandom_range(20, 40);
    mode = 3'd1;
    burst_len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({oe, done, d1, d2, word_cnt} !== {2'b10, 16'hFF00, 16'(k + 1)}) begin
        fails++;
        $display("FAIL cont_w%0d: got oe=%b done=%b d1=%h d2=%h cnt=%0d want FF 00 cnt=%0d",
                 k, oe, done, d1, d2, word_cnt, k + 1);
      end
      tick();
    end
    enable = 1'b0;
    tick();
    checks++;
    if ({oe, busy, done, d1, d2, word_cnt} !== {3'b000, 16'h0, 16'(n + 1)}) begin
      fails++;
      $display("FAIL cont_stop: got oe=%b busy=%b done=%b d1=%h d2=%h cnt=%0d want 0s cnt=%0d",
               oe, busy, done, d1, d2, word_cnt, n + 1);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL cont_nodone: got done=%b want 0", done);
    end
    enable = 1'b1;
  endtask

  task automatic test_enable_drop;
    int m;
    m = $urandom_range(1, 5);
    mode = 3'(m);
    burst_len = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({oe, busy, done, d1, d2, word_cnt} !== {3'b000, 16'h0, 16'd6}) begin
        fails++;
        $display("FAIL endrop_c%0d: got oe=%b busy=%b done=%b d1=%h d2=%h cnt=%0d want 0s cnt=6",
                 c, oe, busy, done, d1, d2, word_cnt);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    mode = 3'd3;
    burst_len = 16'd2;
    start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if ({done, oe} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_done: got done=%b oe=%b want 1 0", done, oe);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy);
    end
    tick();
    checks++;
    if ({busy, oe, word_cnt} !== {2'b10, 16'd0}) begin
      fails++;
      $display("FAIL b2b_rearm: got busy=%b oe=%b cnt=%0d want 1 0 0", busy, oe, word_cnt);
    end
    start = 1'b0;
    tick();
    checks++;
    if ({oe, d1, d2} !== {1'b1, model(3, 0)}) begin
      fails++;
      $display("FAIL b2b_w0: got oe=%b d1=%h d2=%h want %h", oe, d1, d2, model(3, 0));
    end
    repeat (3) tick();
  endtask

  task automatic test_prbs7;
    for (int pass = 0; pass < 2; pass++) begin
      int stop_at;
      stop_at = (pass == 0) ? 127 : 50;
      mode = 3'd5;
      burst_len = 16'd127;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < stop_at; k++) begin
        checks++;
        if ({oe, d1, d2} !== {1'b1, model(5, k)}) begin
          fails++;
          $display("FAIL prbs_p%0d_w%0d: got oe=%b d1=%h d2=%h want %h",
                   pass, k, oe, d1, d2, model(5, k));
        end
        tick();
      end
      if (pass == 0) begin
        checks++;
        if ({done, word_cnt} !== {1'b1, 16'd127}) begin
          fails++;
          $display("FAIL prbs_done: got done=%b cnt=%0d want 1 127", done, word_cnt);
        end
        tick();
      end else begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({d1, d2, oe, busy, done, word_cnt} !== '0) begin
          fails++;
          $display("FAIL prbs_rst: got d1=%h d2=%h oe=%b busy=%b cnt=%0d want all 0",
                   d1, d2, oe, busy, word_cnt);
        end
        tick();
      end
    end
  endtask

`ifdef ODDR_PATGEN_ERR_INJ_EN
  task automatic test_err_inj;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode = 3'd5;
    burst_len = 16'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (10) tick();
    err_inj = 1'b1;
    tick();
    err_inj = 1'b0;
    checks++;
    if ({d1, d2} !== (model(5, 11) ^ 16'h0100)) begin
      fails++;
      $display("FAIL errinj_w11: got %h%h want %h", d1, d2, model(5, 11) ^ 16'h0100);
    end
    tick();
    checks++;
    if ({d1, d2, err_cnt} !== {model(5, 12), 8'd1}) begin
      fails++;
      $display("FAIL errinj_w12: got %h%h cnt=%0d want %h cnt=1",
               d1, d2, err_cnt, model(5, 12));
    end
    repeat (25) tick();
  endtask
`endif

  initial begin
    build_prbs();
    enable = 1'b0;
    start = 1'b0;
    mode = '0;
    burst_len = '0;
    rst_n = 1'b0;
`ifdef ODDR_PATGEN_ERR_INJ_EN
    err_inj = 1'b0;
`endif
    test_reset();
    test_count();
    test_walk1();
    test_random_bursts();
    test_continuous();
    test_enable_drop();
    test_back_to_back();
    test_prbs7();
`ifdef ODDR_PATGEN_ERR_INJ_EN
    test_err_inj();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
